min_vertex_scan: RTL

Sequential arg-min scanner for the shortest-path engine. It walks the 11 per-vertex distance registers through the shared 11-way select mux. It finds the unvisited vertex with the smallest finite tentative distance and returns that vertex's index as the mux select for the relax stage. It sits directly upstream of the 11-way mux: it produces the 4-bit select and consumes the mux output.

---
 rtl/min_vertex_scan_pkg.sv | 17 +
 rtl/min_vertex_scan.sv | 108 ++++++++++
 2 files changed

// File: rtl/min_vertex_scan_pkg.sv
// Shared constants and state encoding for the shortest-path min-vertex scanner.
// The default sizes are also used by the 11-way mux instance and the relax stage.
package min_vertex_scan_pkg;

    localparam int DEF_NUM_NODES = 11;
    localparam int DEF_IDX_W     = 4;
    localparam int DEF_DIST_W    = 16;

    localparam logic [DEF_DIST_W-1:0] DIST_INF = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/min_vertex_scan.sv
// Sequential arg-min scanner: walks the vertex distance mux one index per cycle
// and returns the unvisited vertex with the smallest finite distance.
module min_vertex_scan
    import min_vertex_scan_pkg::*;
#(
    parameter int NUM_NODES = DEF_NUM_NODES,
    parameter int DIST_W    = DEF_DIST_W,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [DIST_W-1:0] dist_in,
    input  logic              visited_in,
    output logic [IDX_W-1:0]  rd_idx,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  min_sel,
    output logic [DIST_W-1:0] min_dist,
    output logic              found
);

    localparam logic [DIST_W-1:0] INF  = '1;
    localparam logic [IDX_W-1:0]  LAST = IDX_W'(NUM_NODES - 1);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [DIST_W-1:0] best_dist;
    logic [IDX_W-1:0]  best_idx;
    logic              found_r;

    logic              candidate;
    logic [DIST_W-1:0] next_dist;
    logic [IDX_W-1:0]  next_idx;
    logic              next_found;

    // Strict compare keeps the earliest index on ties; the last entry must be
    // folded in before committing, so the commit uses the post-compare values.
    always_comb begin
        candidate  = !visited_in && (dist_in != INF) && (dist_in < best_dist);
        next_dist  = best_dist;
        next_idx   = best_idx;
        next_found = found_r;
        if (candidate) begin
            next_dist  = dist_in;
            next_idx   = idx;
            next_found = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            best_dist <= INF;
            best_idx  <= '0;
            found_r   <= 1'b0;
            min_sel   <= '0;
            min_dist  <= INF;
            found     <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= SCAN;
                        idx       <= '0;
                        best_dist <= INF;
                        best_idx  <= '0;
                        found_r   <= 1'b0;
                    end
                end
                SCAN: begin
                    best_dist <= next_dist;
                    best_idx  <= next_idx;
                    found_r   <= next_found;
                    if (idx == LAST) begin
                        state    <= DONE;
                        min_sel  <= next_idx;
                        min_dist <= next_dist;
                        found    <= next_found;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                // First DONE cycle arms the pulse, second cycle carries it;
                // start stays ignored while the pulse is visible.
                DONE: begin
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign rd_idx = (state == SCAN) ? idx : min_sel;

endmodule
